// File: rtl/reset_sequencer_pkg.sv
// Shared types and width helpers for the reset sequencer.
package reset_sequencer_pkg;

   // Sequencer states: hold all resets, wait on one stage's ack, sequence finished.
   typedef enum logic [1:0] {
      ST_ASSERT = 2'd0,
      ST_WAIT   = 2'd1,
      ST_IDLE   = 2'd2
   } seq_state_e;

   // Width of the stage index for a given stage count (at least one bit).
   function automatic int unsigned idx_width(input int unsigned n_stages);
      return (n_stages > 1) ? $clog2(n_stages) : 1;
   endfunction

   // Width of the shared hold/timeout counter: enough to reach max(hold, timeout)-1.
   function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                             input int unsigned ack_timeout);
      int unsigned m;
      m = (hold_cycles > ack_timeout) ? hold_cycles : ack_timeout;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/reset_sequencer.sv
// Orders the release of N_STAGES downstream resets: hold all of them for
// HOLD_CYCLES, then release one stage at a time, moving on when that stage
// acknowledges or after ACK_TIMEOUT cycles (flagging a sticky timeout error).
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned N_STAGES    = 3,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned ACK_TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic [N_STAGES-1:0] stage_ack,
   output logic [N_STAGES-1:0] stage_reset,
   output logic                busy,
   output logic                done,
   output logic [N_STAGES-1:0] timeout_err
);

   localparam int unsigned IDX_W = idx_width(N_STAGES);
   localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, ACK_TIMEOUT);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_STAGES - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

   seq_state_e          state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [N_STAGES-1:0] stage_reset_q, stage_reset_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [N_STAGES-1:0] timeout_err_q, timeout_err_d;

   logic                cur_ack;
   logic                cur_timeout;

   // Next-state logic: req restarts from any state; otherwise hold, then walk the stages.
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
      state_d       = state_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      stage_reset_d = stage_reset_q;
      busy_d        = busy_q;
      done_d        = 1'b0;
      timeout_err_d = timeout_err_q;
      cur_ack       = stage_ack[idx_q];
      cur_timeout   = (cnt_q == ACK_LAST);

      if (req) begin
         state_d       = ST_ASSERT;
         idx_d         = '0;
         cnt_d         = '0;
         stage_reset_d = '1;
         busy_d        = 1'b1;
         timeout_err_d = '0;
      end else begin
         case (state_q)
            ST_ASSERT: begin
               stage_reset_d = '1;
               busy_d        = 1'b1;
               if (cnt_q == HOLD_LAST) begin
                  state_d          = ST_WAIT;
                  idx_d            = '0;
                  cnt_d            = '0;
                  stage_reset_d[0] = 1'b0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            ST_WAIT: begin
               busy_d = 1'b1;
               if (cur_ack || cur_timeout) begin
                  // A timeout advances exactly like an ack, but leaves a sticky flag.
                  if (!cur_ack) begin
                     timeout_err_d[idx_q] = 1'b1;
                  end
                  cnt_d = '0;
                  if (idx_q == LAST_IDX) begin
                     state_d       = ST_IDLE;
                     stage_reset_d = '0;
                     busy_d        = 1'b0;
                     done_d        = 1'b1;
                  end else begin
                     idx_d = idx_q + 1'b1;
                     for (int i = 0; i < int'(N_STAGES); i++) begin
                        stage_reset_d[i] = (i > int'(idx_d));
                     end
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end

            ST_IDLE: begin
               stage_reset_d = '0;
               busy_d        = 1'b0;
            end

            default: begin
               state_d       = ST_ASSERT;
               idx_d         = '0;
               cnt_d         = '0;
               stage_reset_d = '1;
               busy_d        = 1'b1;
            end
         endcase
      end
   end

   // State and registered outputs; async reset holds every stage in reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_ASSERT;
         idx_q         <= '0;
         cnt_q         <= '0;
         stage_reset_q <= '1;
         busy_q        <= 1'b1;
         done_q        <= 1'b0;
         timeout_err_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q       <= state_d;
         idx_q         <= idx_d;
         cnt_q         <= cnt_d;
         stage_reset_q <= stage_reset_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign stage_reset = stage_reset_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with default parameters (3 stages,
// 16-cycle hold, 1024-cycle ack timeout).
module tb_reset_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       req;
   logic [2:0] stage_ack;
   logic [2:0] stage_reset;
   logic       busy;
   logic       done;
   logic [2:0] timeout_err;

   int n_cmp = 0;
   int n_err = 0;

   reset_sequencer #(
      .N_STAGES   (3),
      .HOLD_CYCLES(16),
      .ACK_TIMEOUT(1024)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .stage_ack  (stage_ack),
      .stage_reset(stage_reset),
      .busy       (busy),
      .done       (done),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse reset across two edges and release it just after an edge.
   task automatic do_reset();
      reset = 1'b1;
      req   = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      req       = 1'b0;
      stage_ack = 3'b111;
      #3;
      n_cmp++;
      if (stage_reset !== 3'b111) begin
         n_err++; $display("FAIL rst_stage_reset: got %b want 111", stage_reset);
      end
      n_cmp++;
      if (busy !== 1'b1) begin
         n_err++; $display("FAIL rst_busy: got %b want 1", busy);
      end
      n_cmp++;
      if (done !== 1'b0) begin
         n_err++; $display("FAIL rst_done: got %b want 0", done);
      end
      n_cmp++;
      if (timeout_err !== 3'b000) begin
         n_err++; $display("FAIL rst_timeout_err: got %b want 000", timeout_err);
      end
   endtask

   // All acks high: 16-edge hold, then 110, 100, 000, then done with busy falling.
   task automatic test_power_on();
      stage_ack = 3'b111;
      do_reset();
      for (int e = 1; e <= 15; e++) begin
         step();
         n_cmp++;
         if (stage_reset !== 3'b111 || busy !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL po_hold edge %0d: got rst=%b busy=%b done=%b want 111/1/0",
                     e, stage_reset, busy, done);
         end
      end
      step();
      n_cmp++;
      if (stage_reset !== 3'b110) begin
         n_err++; $display("FAIL po_stage0: got %b want 110", stage_reset);
      end
      step();
      n_cmp++;
      if (stage_reset !== 3'b100) begin
         n_err++; $display("FAIL po_stage1: got %b want 100", stage_reset);
      end
      step();
      n_cmp++;
      if (stage_reset !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin
         n_err++;
         $display("FAIL po_stage2: got rst=%b busy=%b done=%b want 000/1/0",
                  stage_reset, busy, done);
      end
      step();
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         n_err++; $display("FAIL po_done: got done=%b busy=%b want 1/0", done, busy);
      end
      step();
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || stage_reset !== 3'b000 || timeout_err !== 3'b000) begin
         n_err++;
         $display("FAIL po_idle: got done=%b busy=%b rst=%b err=%b want 0/0/000/000",
                  done, busy, stage_reset, timeout_err);
      end
   endtask

   // Stage 1 never acks: it times out 1024 cycles after its release.
   task automatic test_timeout();
      stage_ack = 3'b101;
      do_reset();
      repeat (16) step();
      step();
      n_cmp++;
      if (stage_reset !== 3'b100) begin
         n_err++; $display("FAIL to_stage1_rel: got %b want 100", stage_reset);
      end
      repeat (1023) step();
      n_cmp++;
      if (stage_reset !== 3'b100 || timeout_err !== 3'b000) begin
         n_err++;
         $display("FAIL to_before: got rst=%b err=%b want 100/000", stage_reset, timeout_err);
      end
      step();
      n_cmp++;
      if (stage_reset !== 3'b000 || timeout_err !== 3'b010 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL to_expire: got rst=%b err=%b busy=%b want 000/010/1",
                  stage_reset, timeout_err, busy);
      end
      step();
      n_cmp++;
      if (done !== 1'b1 || busy !== 1'b0 || timeout_err !== 3'b010) begin
         n_err++;
         $display("FAIL to_done: got done=%b busy=%b err=%b want 1/0/010",
                  done, busy, timeout_err);
      end
   endtask

   // ack[0] rises 5 cycles after stage 0 release: stage 1 follows on the next edge.
   task automatic test_late_ack();
      stage_ack = 3'b110;
      do_reset();
      repeat (16) step();
      for (int c = 1; c <= 5; c++) begin
         step();
         n_cmp++;
         if (stage_reset !== 3'b110) begin
            n_err++; $display("FAIL la_wait cycle %0d: got %b want 110", c, stage_reset);
         end
      end
      stage_ack = 3'b111;
      step();
      n_cmp++;
      if (stage_reset !== 3'b100) begin
         n_err++; $display("FAIL la_stage1: got %b want 100", stage_reset);
      end
      step();
      step();
      n_cmp++;
      if (done !== 1'b1 || timeout_err !== 3'b000) begin
         n_err++;
         $display("FAIL la_done: got done=%b err=%b want 1/000", done, timeout_err);
      end
   endtask

   // req while in WAIT(1) with timeout_err[0] set restarts with a full hold.
   task automatic test_req_restart();
      stage_ack = 3'b100;
      do_reset();
      repeat (16) step();
      repeat (1024) step();
      n_cmp++;
      if (stage_reset !== 3'b100 || timeout_err !== 3'b001) begin
         n_err++;
         $display("FAIL rq_pre: got rst=%b err=%b want 100/001", stage_reset, timeout_err);
      end
      repeat (3) step();
      req = 1'b1;
      step();
      req = 1'b0;
      stage_ack = 3'b111;
      n_cmp++;
      if (stage_reset !== 3'b111 || timeout_err !== 3'b000 || busy !== 1'b1 || done !== 1'b0) begin
         n_err++;
         $display("FAIL rq_restart: got rst=%b err=%b busy=%b done=%b want 111/000/1/0",
                  stage_reset, timeout_err, busy, done);
      end
      repeat (15) step();
      n_cmp++;
      if (stage_reset !== 3'b111) begin
         n_err++; $display("FAIL rq_hold: got %b want 111", stage_reset);
      end
      step();
      n_cmp++;
      if (stage_reset !== 3'b110) begin
         n_err++; $display("FAIL rq_release: got %b want 110", stage_reset);
      end
   endtask

   // req on the same edge as the final ack: no done, back to ASSERT.
   task automatic test_req_with_done();
      stage_ack = 3'b111;
      do_reset();
      repeat (18) step();
      n_cmp++;
      if (stage_reset !== 3'b000 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL rd_pre: got rst=%b busy=%b want 000/1", stage_reset, busy);
      end
      req = 1'b1;
      step();
      req = 1'b0;
      n_cmp++;
      if (done !== 1'b0 || stage_reset !== 3'b111 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL rd_collide: got done=%b rst=%b busy=%b want 0/111/1",
                  done, stage_reset, busy);
      end
      step();
      n_cmp++;
      if (done !== 1'b0 || stage_reset !== 3'b111) begin
         n_err++;
         $display("FAIL rd_after: got done=%b rst=%b want 0/111", done, stage_reset);
      end
   endtask

   // Async reset between edges mid-WAIT takes effect immediately, then the sequence reruns.
   task automatic test_async_reset();
      stage_ack = 3'b101;
      do_reset();
      repeat (20) step();
      n_cmp++;
      if (stage_reset !== 3'b100) begin
         n_err++; $display("FAIL ar_pre: got %b want 100", stage_reset);
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (stage_reset !== 3'b111 || busy !== 1'b1 || done !== 1'b0) begin
         n_err++;
         $display("FAIL ar_immediate: got rst=%b busy=%b done=%b want 111/1/0",
                  stage_reset, busy, done);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      stage_ack = 3'b111;
      repeat (15) step();
      n_cmp++;
      if (stage_reset !== 3'b111) begin
         n_err++; $display("FAIL ar_hold: got %b want 111", stage_reset);
      end
      step();
      n_cmp++;
      if (stage_reset !== 3'b110) begin
         n_err++; $display("FAIL ar_release: got %b want 110", stage_reset);
      end
   endtask

   initial begin
      reset     = 1'b1;
      req       = 1'b0;
      stage_ack = 3'b111;
      test_reset();
      test_power_on();
      test_timeout();
      test_late_ack();
      test_req_restart();
      test_req_with_done();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
